// File: rtl/tokenizer_engine_if.sv
// AXI4-Lite master-side bundle used by tokenizer_engine (no BRESP, WSTRB fixed by the engine).
interface tokenizer_engine_if #(
    parameter int unsigned AXI_ADDR_WIDTH = 32
) ();
    logic [AXI_ADDR_WIDTH-1:0] araddr;
    logic                      arvalid;
    logic                      arready;
    logic [31:0]               rdata;
    logic                      rvalid;
    logic                      rready;
    logic [AXI_ADDR_WIDTH-1:0] awaddr;
    logic                      awvalid;
    logic                      awready;
    logic [31:0]               wdata;
    logic [3:0]                wstrb;
    logic                      wvalid;
    logic                      wready;
    logic                      bvalid;
    logic                      bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rvalid, awready, wready, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rvalid, awready, wready, bvalid
    );
endinterface

// File: rtl/tokenizer_engine.sv
// Fetches a NUL-terminated string word by word over AXI4-Lite, scans it byte by byte and
// writes a table of token start offsets followed by a 0xFFFF_FFFF terminator.
module tokenizer_engine #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned MAX_TOKENS     = 64,
    parameter int unsigned MAX_LEN        = 4096
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    input  logic [AXI_ADDR_WIDTH-1:0] str_addr,
    input  logic [AXI_ADDR_WIDTH-1:0] out_addr,
    output logic                      idle,
    output logic [15:0]               token_count,
    tokenizer_engine_if.master        axi
);
    localparam int unsigned AW = AXI_ADDR_WIDTH;

    typedef enum logic [2:0] {StIdle, StRdAddr, StRdData, StScan, StWr, StWrTerm} state_e;

    state_e        state_q, state_d, after_byte;
    logic [AW-1:0] str_q, out_q, offset_q, offset_inc;
    logic [31:0]   rdata_q;
    logic [15:0]   count_q, token_count_q;
    logic          prev_space_q, aw_done_q, w_done_q;
    logic [7:0]    cur_byte;
    logic          is_end, tok_start, can_write, wr_state, aw_hs, w_hs, b_hs;

    assign cur_byte   = rdata_q[{offset_q[1:0], 3'b000} +: 8];
    assign is_end     = (offset_q == AW'(MAX_LEN)) || (cur_byte == 8'h00);
    assign tok_start  = prev_space_q && (cur_byte != 8'h20);
    assign can_write  = count_q < 16'(MAX_TOKENS);
    assign offset_inc = offset_q + AW'(1);
    assign wr_state   = (state_q == StWr) || (state_q == StWrTerm);
    assign aw_hs      = wr_state && !aw_done_q && axi.awready;
    assign w_hs       = wr_state && !w_done_q && axi.wready;
    assign b_hs       = wr_state && aw_done_q && w_done_q && axi.bvalid;

    // Where to go once the current byte is consumed; a word boundary that is also the length
    // limit terminates without fetching another word.
    always_comb begin
        after_byte = StScan;
        if (offset_inc[1:0] == 2'b00) begin
            after_byte = (offset_inc == AW'(MAX_LEN)) ? StWrTerm : StRdAddr;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StRdAddr;
            StRdAddr: if (axi.arready) state_d = StRdData;
            StRdData: if (axi.rvalid) state_d = StScan;
            StScan: begin
                if (is_end) state_d = StWrTerm;
                else if (tok_start && can_write) state_d = StWr;
                else state_d = after_byte;
            end
            StWr:     if (b_hs) state_d = after_byte;
            StWrTerm: if (b_hs) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            str_q         <= '0;
            out_q         <= '0;
            offset_q      <= '0;
            rdata_q       <= '0;
            count_q       <= '0;
            token_count_q <= '0;
            prev_space_q  <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
        end else begin
            if (state_q == StIdle && start) begin
                str_q        <= str_addr & ~AW'(3);
                out_q        <= out_addr & ~AW'(3);
                offset_q     <= '0;
                count_q      <= '0;
                prev_space_q <= 1'b1;
            end
            if (state_q == StRdData && axi.rvalid) rdata_q <= axi.rdata;
            if (state_q == StScan && !is_end && !(tok_start && can_write)) begin
                offset_q     <= offset_inc;
                prev_space_q <= (cur_byte == 8'h20);
            end
            // The slot index is the pre-increment count, so count advances only after B.
            if (state_q == StWr && b_hs) begin
                offset_q     <= offset_inc;
                prev_space_q <= 1'b0;
                count_q      <= count_q + 16'd1;
            end
            if (state_q == StWrTerm && b_hs) token_count_q <= count_q;
            if (b_hs) begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end else begin
                if (aw_hs) aw_done_q <= 1'b1;
                if (w_hs) w_done_q <= 1'b1;
            end
        end
    end

    always_comb begin
        idle        = (state_q == StIdle);
        token_count = token_count_q;
        axi.araddr  = str_q + {offset_q[AW-1:2], 2'b00};
        axi.arvalid = (state_q == StRdAddr);
        axi.rready  = (state_q == StRdData);
        axi.awaddr  = out_q + AW'({count_q, 2'b00});
        axi.awvalid = wr_state && !aw_done_q;
        axi.wvalid  = wr_state && !w_done_q;
        axi.wdata   = (state_q == StWrTerm) ? 32'hFFFF_FFFF : 32'(offset_q);
        axi.wstrb   = 4'hF;
        axi.bready  = wr_state && aw_done_q && w_done_q;
    end
endmodule
